md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Sequencing controller for the multiply/divide resource (HI/LO) in the E stage of the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from E, runs a fixed-latency busy countdown, commits results to HI/LO, and raises a stall request to the hazard unit whenever the instruction in D needs the unit while it is occupied. Exception cancellation from the exception/CP0 logic suppresses issue in the cancelling cycle.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- MDOp_E_I  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A_E_I  in  32  forwarded rs value
- B_E_I  in  32  forwarded rt value
- Cancel_I  in  1  exception/interrupt taken this cycle; E-stage op must not issue
- MDUse_D_I  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy_O  out  1  operation in flight
- Stall_O  out  1  stall request to hazard unit
- HI_O  out  32  HI register
- LO_O  out  32  LO register

## Operation
- States: IDLE, RUN. Reset → IDLE, counter 0, HI=0, LO=0, Busy_O=0.
- Issue (IDLE, Cancel_I=0, op 1–4): latch A, B, op; load counter with MULT_CYCLES or DIV_CYCLES; go RUN next edge.
- RUN: decrement counter every cycle; when counter reaches 1, commit result on that edge and return to IDLE.
- Results: mult → {HI,LO}=signed(A)×signed(B) 64-bit; multu → unsigned 64-bit product; div → LO=signed quotient truncated toward zero, HI=remainder with sign of dividend; divu → unsigned quotient/remainder.
- Divide by zero (B=0): completes full DIV_CYCLES, HI/LO unchanged.
- Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (IDLE, Cancel_I=0): write A_E_I to HI/LO on that edge; no busy.
- Cancel_I=1: op present that cycle has no effect (no issue, no mthi/mtlo write). Cancel never aborts an operation already in RUN; it completes and commits.
- Op 1–6 presented while in RUN: ignored (hazard unit guarantees it cannot occur; design must not corrupt state if it does).
- Stall_O = MDUse_D_I & (Busy_O | issue_this_cycle), where issue_this_cycle = op in 1–4 & ~Cancel_I & IDLE. Combinational from inputs and state.
- HI_O/LO_O are register outputs; mfhi/mflo read them directly.

## Timing
- Issue at edge t (op valid in cycle t-1… i.e. op sampled at edge t): Busy_O=1 for exactly N cycles after edge t, N=MULT_CYCLES or DIV_CYCLES.
- Result visible on HI_O/LO_O in the same cycle Busy_O falls to 0 (N edges after issue edge).
- Back-to-back: a new op issued in the first cycle with Busy_O=0 is accepted.
- mthi/mtlo: HI_O/LO_O update one edge after sample, Busy_O stays 0.
- Reset asserted mid-RUN: next edge returns IDLE, Busy_O=0, HI=LO=0, no commit.
- Stall_O asserted in the issue cycle and all N busy cycles when MDUse_D_I=1; deasserts in the cycle Busy_O falls.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3 → Busy_O high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → Busy_O high 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7,B=0 → HI/LO unchanged after 10 cycles.
- MDUse_D_I=1 held through mult issue → Stall_O high issue cycle + 5 busy cycles, low when Busy_O=0; with MDUse_D_I=0 Stall_O stays 0.
- mtlo A=0x12345678 with Cancel_I=1 → LO unchanged, Busy_O=0; same with Cancel_I=0 → LO=0x12345678 next cycle; mult issued with Cancel_I=1 → Busy_O never rises.
- Cancel_I pulsed during RUN of div → still completes at cycle 10 with correct HI/LO.
- reset asserted in busy cycle 3 of div → Busy_O=0, HI=LO=0 next cycle, no later commit; mult issued immediately after → correct result.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - HI/LO multiply/divide sequencer with busy countdown and D-stage stall request
// Fixed-latency unit: operands latched at issue, result committed on the last busy edge.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MDOp_E_I,
   input  logic [31:0] A_E_I,
   input  logic [31:0] B_E_I,
   input  logic        Cancel_I,
   input  logic        MDUse_D_I,
   output logic        Busy_O,
   output logic        Stall_O,
   output logic [31:0] HI_O,
   output logic [31:0] LO_O
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     op_q, op_d;
   logic [31:0]    a_q, a_d, b_q, b_d;
   logic [31:0]    hi_q, hi_d, lo_q, lo_d;

   logic           issue;
   logic           res_we;
   logic [31:0]    res_hi, res_lo;
   logic [63:0]    prod_s, prod_u;
   logic [31:0]    quot_s, rem_s, quot_u, rem_u;
   logic           div_ovf;

   assign issue = (state_q == IDLE) && !Cancel_I &&
                  (MDOp_E_I >= OP_MULT) && (MDOp_E_I <= OP_DIVU);

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // The only signed quotient that overflows 32 bits wraps back to the dividend.
   assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

   always_comb begin
      quot_s = 32'd0;
      rem_s  = 32'd0;
      quot_u = 32'd0;
      rem_u  = 32'd0;
      if (b_q != 32'd0) begin
         quot_u = a_q / b_q;
         rem_u  = a_q % b_q;
         if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
         end else begin
            quot_s = $signed(a_q) / $signed(b_q);
            rem_s  = $signed(a_q) % $signed(b_q);
         end
      end
   end

   always_comb begin
      res_we = 1'b0;
      res_hi = hi_q;
      res_lo = lo_q;
      case (op_q)
         OP_MULT: begin
            res_we = 1'b1;
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_we = 1'b1;
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            res_we = (b_q != 32'd0);
            res_hi = rem_s;
            res_lo = quot_s;
         end
         OP_DIVU: begin
            res_we = (b_q != 32'd0);
            res_hi = rem_u;
            res_lo = quot_u;
         end
         default: res_we = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               op_d    = MDOp_E_I;
               a_d     = A_E_I;
               b_d     = B_E_I;
               cnt_d   = (MDOp_E_I <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               state_d = RUN;
            end else if (!Cancel_I && MDOp_E_I == OP_MTHI) begin
               hi_d = A_E_I;
            end else if (!Cancel_I && MDOp_E_I == OP_MTLO) begin
               lo_d = A_E_I;
            end
         end
         RUN: begin
            // New ops arriving here are dropped; Cancel_I never aborts a running op.
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (res_we) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy_O  = (state_q == RUN);
   assign Stall_O = MDUse_D_I & (Busy_O | issue);
   assign HI_O    = hi_q;
   assign LO_O    = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - randomized and directed bench for md_unit_ctrl against a behavioural HI/LO model
module tb_md_unit_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  MDOp_E_I;
   logic [31:0] A_E_I, B_E_I;
   logic        Cancel_I, MDUse_D_I;
   logic        Busy_O, Stall_O;
   logic [31:0] HI_O, LO_O;

   md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .MDOp_E_I(MDOp_E_I), .A_E_I(A_E_I), .B_E_I(B_E_I),
      .Cancel_I(Cancel_I), .MDUse_D_I(MDUse_D_I), .Busy_O(Busy_O), .Stall_O(Stall_O),
      .HI_O(HI_O), .LO_O(LO_O)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nb, ns;

   int          m_left;
   logic [2:0]  m_op;
   logic [31:0] m_a, m_b, m_hi, m_lo;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_commit();
      longint sa, sb, p, na, nd, q, r;
      logic [63:0] pu;
      logic [63:0] qv, rv;
      case (m_op)
         3'd1: begin
            sa = longint'(int'(m_a));
            sb = longint'(int'(m_b));
            p  = sa * sb;
            pu = p;
            m_hi = pu[63:32];
            m_lo = pu[31:0];
         end
         3'd2: begin
            pu = {32'd0, m_a} * {32'd0, m_b};
            m_hi = pu[63:32];
            m_lo = pu[31:0];
         end
         3'd3: if (m_b != 0) begin
            sa = longint'(int'(m_a));
            sb = longint'(int'(m_b));
            na = (sa < 0) ? -sa : sa;
            nd = (sb < 0) ? -sb : sb;
            q  = na / nd;
            r  = na % nd;
            if ((sa < 0) != (sb < 0)) q = -q;
            if (sa < 0) r = -r;
            qv = q;
            rv = r;
            m_lo = qv[31:0];
            m_hi = rv[31:0];
         end
         3'd4: if (m_b != 0) begin
            m_lo = m_a / m_b;
            m_hi = m_a % m_b;
         end
         default: ;
      endcase
   endtask

   task automatic model_step(input logic [2:0] op, input logic [31:0] a, b, input bit cn, rs);
      if (rs) begin
         m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) model_commit();
      end else if (!cn) begin
         if (op >= 1 && op <= 4) begin
            m_op = op; m_a = a; m_b = b;
            m_left = (op <= 2) ? MC : DC;
         end else if (op == 5) m_hi = a;
         else if (op == 6) m_lo = a;
      end
   endtask

   // One pipeline cycle: drive, check the combinational stall, clock, check state.
   task automatic cyc(input logic [2:0] op, input logic [31:0] a, b, input bit cn, mu, rs);
      bit exp_stall;
      MDOp_E_I = op; A_E_I = a; B_E_I = b; Cancel_I = cn; MDUse_D_I = mu; reset = rs;
      #1;
      exp_stall = mu && ((m_left > 0) || (op >= 1 && op <= 4 && !cn));
      chk("stall", {31'd0, Stall_O}, {31'd0, exp_stall});
      ns += int'(Stall_O);
      @(posedge clk);
      model_step(op, a, b, cn, rs);
      @(negedge clk);
      chk("busy", {31'd0, Busy_O}, {31'd0, (m_left > 0)});
      chk("hi", HI_O, m_hi);
      chk("lo", LO_O, m_lo);
      nb += int'(Busy_O);
   endtask

   task automatic idle(input int n, input bit mu);
      for (int i = 0; i < n; i++) cyc(3'd0, 32'd0, 32'd0, 1'b0, mu, 1'b0);
   endtask

   initial begin
      m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
      nb = 0; ns = 0;
      MDOp_E_I = 0; A_E_I = 0; B_E_I = 0; Cancel_I = 0; MDUse_D_I = 0; reset = 1;
      @(negedge clk);
      cyc(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      cyc(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("reset_busy", {31'd0, Busy_O}, 32'd0);
      chk("reset_hi", HI_O, 32'd0);
      chk("reset_lo", LO_O, 32'd0);

      nb = 0; ns = 0;
      cyc(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b0);
      idle(6, 1'b1);
      chk("mult_busy_cycles", nb, 32'd5);
      chk("mult_stall_cycles", ns, 32'd6);
      chk("mult_hi", HI_O, 32'hFFFF_FFFF);
      chk("mult_lo", LO_O, 32'hFFFF_FFFA);

      nb = 0; ns = 0;
      cyc(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
      idle(6, 1'b0);
      chk("multu_stall_cycles", ns, 32'd0);
      chk("multu_hi", HI_O, 32'h0000_0002);
      chk("multu_lo", LO_O, 32'hFFFF_FFFA);

      nb = 0;
      cyc(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      cyc(3'd6, 32'h5555_5555, 32'd0, 1'b1, 1'b0, 1'b0);
      idle(7, 1'b0);
      chk("div_busy_cycles", nb, 32'd10);
      chk("div_hi", HI_O, 32'hFFFF_FFFF);
      chk("div_lo", LO_O, 32'hFFFF_FFFD);

      nb = 0;
      cyc(3'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
      idle(11, 1'b0);
      chk("divz_busy_cycles", nb, 32'd10);
      chk("divz_hi", HI_O, 32'hFFFF_FFFF);
      chk("divz_lo", LO_O, 32'hFFFF_FFFD);

      nb = 0;
      cyc(3'd6, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("mtlo_cancel_lo", LO_O, 32'hFFFF_FFFD);
      cyc(3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("mtlo_lo", LO_O, 32'h1234_5678);
      cyc(3'd5, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("mthi_hi", HI_O, 32'hCAFE_0001);
      cyc(3'd1, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
      idle(6, 1'b0);
      chk("mt_cancel_busy_cycles", nb, 32'd0);

      cyc(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      idle(10, 1'b0);
      chk("divovf_lo", LO_O, 32'h8000_0000);
      chk("divovf_hi", HI_O, 32'd0);

      cyc(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      cyc(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_busy", {31'd0, Busy_O}, 32'd0);
      chk("rst_mid_hi", HI_O, 32'd0);
      chk("rst_mid_lo", LO_O, 32'd0);
      cyc(3'd1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
      idle(12, 1'b0);
      chk("post_rst_mult_lo", LO_O, 32'd35);
      chk("post_rst_mult_hi", HI_O, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         bit          cn, mu, rs;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
         cn = ($urandom_range(0, 7) == 0);
         mu = $urandom_range(0, 1) == 1;
         rs = ($urandom_range(0, 99) == 0);
         cyc(op, a, b, cn, mu, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
